// File: rtl/capture_pkg.sv
// ---------------------------------------------------------------------------
// capture_pkg
// Shared definitions for the multichannel capture buffer.
//   cap_state_t : capture state machine encoding (FILL, ARMED, POST, FROZEN)
//   sum_width() : width of a running energy sum that cannot overflow
//   rectify()   : |diff| saturated to the unsigned maximum of data_w bits
// ---------------------------------------------------------------------------
package capture_pkg;

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      ARMED  = 2'd1,
      POST   = 2'd2,
      FROZEN = 2'd3
   } cap_state_t;

   // WINDOW_SIZE values of at most DATA_W bits each need clog2(WINDOW_SIZE)
   // extra bits of headroom.
   function automatic int sum_width(input int window_size, input int data_w);
      return $clog2(window_size) + data_w;
   endfunction

   // diff arrives sign-extended from DATA_W+1 bits. Its magnitude is clamped
   // to 2**data_w-1 so the result always fits the unsigned sample width.
   function automatic logic [31:0] rectify(input logic signed [32:0] diff,
                                           input int data_w);
      logic [32:0] mag;
      logic [32:0] max_val;
      mag     = diff[32] ? 33'(-diff) : 33'(diff);
      max_val = (33'd1 << data_w) - 33'd1;
      if (mag > max_val) mag = max_val;
      return mag[31:0];
   endfunction

endpackage

// File: rtl/multichannel_capture_buffer_if.sv
// ---------------------------------------------------------------------------
// multichannel_capture_buffer_if
// Sample input bus and frozen-buffer read bus of the capture buffer.
//   data     : CHANNELS x DATA_W packed samples, channel 0 in the low bits
//   data_rdy : sample strobe
//   rd_req   : read request
//   rd_idx   : chronological read index, 0 = oldest
//   rd_valid : rd_data valid
//   rd_data  : CHANNELS x DATA_W raw samples at rd_idx
//
// Handshake: data_rdy is a one-cycle strobe with no backpressure; the
// block always accepts the sample. rd_req is accepted only while the
// buffer is frozen, and rd_valid/rd_data follow exactly one cycle after
// each accepted request; requests may be issued every cycle. There is no
// ready signal on either bus.
// ---------------------------------------------------------------------------
interface multichannel_capture_buffer_if #(
   parameter int CHANNELS = 3,
   parameter int DATA_W   = 18,
   parameter int DEPTH    = 512
);
   logic [CHANNELS*DATA_W-1:0] data;
   logic                       data_rdy;
   logic                       rd_req;
   logic [$clog2(DEPTH)-1:0]   rd_idx;
   logic                       rd_valid;
   logic [CHANNELS*DATA_W-1:0] rd_data;

   modport master (
      output data, data_rdy, rd_req, rd_idx,
      input  rd_valid, rd_data
   );

   modport slave (
      input  data, data_rdy, rd_req, rd_idx,
      output rd_valid, rd_data
   );
endinterface

// File: rtl/channel_energy_detector.sv
// ---------------------------------------------------------------------------
// channel_energy_detector
// Rectified running-sum energy detector for one microphone channel.
//   clock, reset_n : clock, asynchronous active-low reset
//   sample         : raw signed sample (DATA_W)
//   sample_rdy     : sample strobe
//   noise_detected : registered, sum of the last WINDOW_SIZE rectified
//                    values > WINDOW_SIZE*THRESHOLD
// ---------------------------------------------------------------------------
module channel_energy_detector
   import capture_pkg::*;
#(
   parameter int                       DATA_W      = 18,
   parameter int                       WINDOW_SIZE = 5,
   parameter int                       THRESHOLD   = 4096,
   parameter logic signed [DATA_W-1:0] CALIB       = '0
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] sample,
   input  logic              sample_rdy,
   output logic              noise_detected
);
   localparam int         SUM_W = sum_width(WINDOW_SIZE, DATA_W);
   localparam logic [63:0] LIMIT = 64'(WINDOW_SIZE) * 64'(THRESHOLD);

   logic signed [DATA_W:0] diff;
   logic [DATA_W-1:0]      rect;
   logic [SUM_W-1:0]       sum_q, sum_d;
   logic [DATA_W-1:0]      win_q [WINDOW_SIZE];

   // The sum always covers the values held in the window, so the subtract
   // never produces a true negative; modular wrap of the intermediate is fine.
   always_comb begin
      diff  = $signed({sample[DATA_W-1], sample}) - $signed({CALIB[DATA_W-1], CALIB});
      rect  = DATA_W'(rectify(33'(diff), DATA_W));
      sum_d = sum_q + SUM_W'(rect) - SUM_W'(win_q[WINDOW_SIZE-1]);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sum_q          <= '0;
         noise_detected <= 1'b0;
         for (int i = 0; i < WINDOW_SIZE; i++) win_q[i] <= '0;
      end else if (sample_rdy) begin
         win_q[0] <= rect;
         for (int i = 1; i < WINDOW_SIZE; i++) win_q[i] <= win_q[i-1];
         sum_q          <= sum_d;
         noise_detected <= 64'(sum_d) > LIMIT;
      end
   end

endmodule

// File: rtl/multichannel_capture_buffer.sv
// ---------------------------------------------------------------------------
// multichannel_capture_buffer
// Per-microphone circular capture buffer with energy trigger. Fills
// DEPTH-POST_TRIG samples of history, arms, triggers on the lowest channel
// whose detector fires, captures POST_TRIG more samples, then freezes for
// chronological readout until rearm.
//   clock, reset_n : clock, asynchronous active-low reset
//   rearm          : one-cycle pulse, restart capture from FILL
//   bus (slave)    : data/data_rdy in, rd_req/rd_idx in, rd_valid/rd_data out
//   noise_detected : live per-channel detector outputs
//   frozen         : capture complete, buffer readable
//   trig_channel   : channel that caused the trigger
//   state_o        : current capture state
//   trig_timestamp : only with CAPTURE_TIMESTAMP_EN defined; sample count
//                    latched at the trigger
// The bus interface instance must use the same CHANNELS/DATA_W/DEPTH.
// ---------------------------------------------------------------------------
module multichannel_capture_buffer
   import capture_pkg::*;
#(
   parameter int                         CHANNELS    = 3,
   parameter int                         DATA_W      = 18,
   parameter int                         DEPTH       = 512,
   parameter int                         WINDOW_SIZE = 5,
   parameter int                         THRESHOLD   = 4096,
   parameter int                         POST_TRIG   = 256,
   parameter logic [CHANNELS*DATA_W-1:0] CALIB_VALS  = '0
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          rearm,
   multichannel_capture_buffer_if.slave  bus,
   output logic [CHANNELS-1:0]           noise_detected,
   output logic                          frozen,
   output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] trig_channel,
   output logic [1:0]                    state_o
`ifdef CAPTURE_TIMESTAMP_EN
   ,
   output logic [31:0]                   trig_timestamp
`endif
);
   localparam int              AW        = $clog2(DEPTH);
   localparam int              TRIG_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int              W         = CHANNELS * DATA_W;
   localparam logic [AW-1:0]   FILL_LAST = AW'(DEPTH - POST_TRIG - 1);
   localparam logic [AW-1:0]   POST_LAST = AW'(POST_TRIG - 1);

   cap_state_t        state_q, state_d;
   logic [AW-1:0]     fill_q, fill_d, post_q, post_d, wr_ptr_q, rd_addr;
   logic [TRIG_W-1:0] trig_q, trig_d;
   logic              wr_en, rd_accept;
   logic              rd_valid_q;
   logic [W-1:0]      rd_data_q;
   logic [W-1:0]      mem [DEPTH];

   for (genvar c = 0; c < CHANNELS; c++) begin : g_det
      channel_energy_detector #(
         .DATA_W      (DATA_W),
         .WINDOW_SIZE (WINDOW_SIZE),
         .THRESHOLD   (THRESHOLD),
         .CALIB       (CALIB_VALS[c*DATA_W +: DATA_W])
      ) u_det (
         .clock          (clock),
         .reset_n        (reset_n),
         .sample         (bus.data[c*DATA_W +: DATA_W]),
         .sample_rdy     (bus.data_rdy),
         .noise_detected (noise_detected[c])
      );
   end

   // A sample arriving with rearm is written even from FROZEN; it is fill
   // sample 1 of the new capture.
   assign wr_en     = bus.data_rdy && ((state_q != FROZEN) || rearm);
   assign rd_accept = bus.rd_req && (state_q == FROZEN);
   // wr_ptr points at the oldest sample once frozen, so the sum is chronological.
   assign rd_addr   = wr_ptr_q + bus.rd_idx;

   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      post_d  = post_q;
      trig_d  = trig_q;
      if (rearm) begin
         state_d = FILL;
         fill_d  = '0;
         post_d  = '0;
         trig_d  = '0;
         if (bus.data_rdy) begin
            if (FILL_LAST == '0) state_d = ARMED;
            else                 fill_d  = AW'(1);
         end
      end else begin
         case (state_q)
            FILL: begin
               // Detections are ignored here so the pre-trigger history is full.
               if (bus.data_rdy) begin
                  if (fill_q == FILL_LAST) begin
                     state_d = ARMED;
                     fill_d  = '0;
                  end else begin
                     fill_d = fill_q + AW'(1);
                  end
               end
            end
            ARMED: begin
               if (|noise_detected) begin
                  state_d = POST;
                  post_d  = '0;
                  // Descending scan leaves the lowest asserted channel.
                  for (int c = CHANNELS - 1; c >= 0; c--) begin
                     if (noise_detected[c]) trig_d = TRIG_W'(c);
                  end
               end
            end
            POST: begin
               if (bus.data_rdy) begin
                  post_d = post_q + AW'(1);
                  if (post_q == POST_LAST) state_d = FROZEN;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= FILL;
         fill_q     <= '0;
         post_q     <= '0;
         trig_q     <= '0;
         wr_ptr_q   <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         fill_q     <= fill_d;
         post_q     <= post_d;
         trig_q     <= trig_d;
         rd_valid_q <= rd_accept;
         if (wr_en)     wr_ptr_q  <= wr_ptr_q + AW'(1);
         if (rd_accept) rd_data_q <= mem[rd_addr];
      end
   end

   // Sample storage is never cleared.
   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_ptr_q] <= bus.data;
   end

   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rd_data_q;
   assign frozen       = (state_q == FROZEN);
   assign trig_channel = trig_q;
   assign state_o      = state_q;

`ifdef CAPTURE_TIMESTAMP_EN
   logic [31:0] sample_cnt_q, ts_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sample_cnt_q <= '0;
         ts_q         <= '0;
      end else begin
         if (bus.data_rdy) sample_cnt_q <= sample_cnt_q + 32'd1;
         if (rearm)                                     ts_q <= '0;
         else if (state_q == ARMED && state_d == POST)  ts_q <= sample_cnt_q;
      end
   end

   assign trig_timestamp = ts_q;
`endif

endmodule

// File: tb/tb_multichannel_capture_buffer.sv
// ---------------------------------------------------------------------------
// tb_multichannel_capture_buffer
// Directed bench for multichannel_capture_buffer. Main instance: 3 channels,
// DEPTH 512, POST_TRIG 256, channel 0 calibrated at 1000. A second, small
// instance with channel 0 calibrated at 131071 exercises rectifier
// saturation. Samples are strobed every other cycle so the trigger decision
// lands in the idle cycle between samples.
// ---------------------------------------------------------------------------
module tb_multichannel_capture_buffer;
   import capture_pkg::*;

   localparam int CH    = 3;
   localparam int DW    = 18;
   localparam int DEPTH = 512;

   logic clock     = 1'b0;
   logic reset_n   = 1'b0;
   logic rearm     = 1'b0;
   logic sat_rearm = 1'b0;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   multichannel_capture_buffer_if #(.CHANNELS(CH), .DATA_W(DW), .DEPTH(DEPTH)) bus ();
   multichannel_capture_buffer_if #(.CHANNELS(CH), .DATA_W(DW), .DEPTH(8))     sat_bus ();

   logic [CH-1:0] nd, sat_nd;
   logic          frz, sat_frz;
   logic [1:0]    trig, sat_trig;
   logic [1:0]    state, sat_state;
`ifdef CAPTURE_TIMESTAMP_EN
   logic [31:0]   ts, sat_ts;
`endif

   multichannel_capture_buffer #(
      .CHANNELS(CH), .DATA_W(DW), .DEPTH(DEPTH), .WINDOW_SIZE(5),
      .THRESHOLD(4096), .POST_TRIG(256),
      .CALIB_VALS({18'd0, 18'd0, 18'd1000})
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .rearm          (rearm),
      .bus            (bus),
      .noise_detected (nd),
      .frozen         (frz),
      .trig_channel   (trig),
      .state_o        (state)
`ifdef CAPTURE_TIMESTAMP_EN
      ,
      .trig_timestamp (ts)
`endif
   );

   multichannel_capture_buffer #(
      .CHANNELS(CH), .DATA_W(DW), .DEPTH(8), .WINDOW_SIZE(5),
      .THRESHOLD(4096), .POST_TRIG(4),
      .CALIB_VALS({18'd0, 18'd0, 18'd131071})
   ) dut_sat (
      .clock          (clock),
      .reset_n        (reset_n),
      .rearm          (sat_rearm),
      .bus            (sat_bus),
      .noise_detected (sat_nd),
      .frozen         (sat_frz),
      .trig_channel   (sat_trig),
      .state_o        (sat_state)
`ifdef CAPTURE_TIMESTAMP_EN
      ,
      .trig_timestamp (sat_ts)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // One sample strobe followed by one idle cycle.
   task automatic send(input int d0, input int d1, input int d2);
      bus.data     = {DW'(d2), DW'(d1), DW'(d0)};
      bus.data_rdy = 1'b1;
      step();
      bus.data_rdy = 1'b0;
      step();
   endtask

   task automatic quiet(input int count);
      repeat (count) send(1000, 0, 0);
   endtask

   task automatic send_sat(input int d0);
      sat_bus.data     = {DW'(0), DW'(0), DW'(d0)};
      sat_bus.data_rdy = 1'b1;
      step();
      sat_bus.data_rdy = 1'b0;
      step();
   endtask

   initial begin
      logic [DW-1:0] e0, e1;

      bus.data         = '0;
      bus.data_rdy     = 1'b0;
      bus.rd_req       = 1'b0;
      bus.rd_idx       = '0;
      sat_bus.data     = '0;
      sat_bus.data_rdy = 1'b0;
      sat_bus.rd_req   = 1'b0;
      sat_bus.rd_idx   = '0;

      // Reset state
      step();
      step();
      check("rst_state",    state,        FILL);
      check("rst_frozen",   frz,          0);
      check("rst_nd",       nd,           0);
      check("rst_trig",     trig,         0);
      check("rst_rd_valid", bus.rd_valid, 0);
      check("rst_rd_data",  bus.rd_data,  0);
      reset_n = 1'b1;
      step();

      // Saturation: -131072 against calibration 131071 gives r = 262143
      repeat (5) send_sat(-131072);
      check("sat_nd_high", sat_nd, 3'b001);
      repeat (4) send_sat(131071);
      check("sat_nd_drain4", sat_nd, 3'b001);
      send_sat(131071);
      check("sat_nd_drain5", sat_nd, 3'b000);

      // Ramp: fill with sample index on every channel
      for (int n = 0; n < 256; n++) begin
         send(n, n, n);
         if (n == 254) check("ramp_fill_255", state, FILL);
      end
      check("ramp_armed_256", state, ARMED);

      // Channel 1 at 5000 for five samples
      for (int k = 0; k < 5; k++) begin
         send(256 + k, 5000, 256 + k);
         if (k == 3) begin
            check("ramp_nd_4th",    nd,    3'b000);
            check("ramp_state_4th", state, ARMED);
         end
      end
      check("ramp_nd_5th",   nd,    3'b010);
      check("ramp_state_5th", state, POST);
      check("ramp_trig",     trig,  1);

      for (int n = 261; n < 517; n++) begin
         send(n, n, n);
         if (n == 515) begin
            check("post_255_state",  state, POST);
            check("post_255_frozen", frz,   0);
         end
      end
      check("post_256_state",  state, FROZEN);
      check("post_256_frozen", frz,   1);
      check("post_trig_hold",  trig,  1);

      // Back-to-back chronological readout: idx i holds sample 5+i
      for (int i = 0; i < DEPTH; i++) begin
         bus.rd_req = 1'b1;
         bus.rd_idx = 9'(i);
         step();
         e0 = DW'(5 + i);
         e1 = (i >= 251 && i <= 255) ? DW'(5000) : DW'(5 + i);
         check($sformatf("rd_idx%0d", i), {bus.rd_valid, bus.rd_data}, {1'b1, e0, e1, e0});
      end
      bus.rd_req = 1'b0;
      step();
      check("rd_valid_drop", bus.rd_valid, 0);

      // Plain rearm, then read attempt outside FROZEN
      rearm = 1'b1;
      step();
      rearm = 1'b0;
      check("rearm_state",  state, FILL);
      check("rearm_frozen", frz,   0);
      check("rearm_trig",   trig,  0);
      bus.rd_req = 1'b1;
      bus.rd_idx = '0;
      step();
      bus.rd_req = 1'b0;
      check("rd_in_fill", bus.rd_valid, 0);
      quiet(255);
      check("tie_fill_255", state, FILL);
      quiet(1);
      check("tie_armed", state, ARMED);

      // Tie: channels 0 and 2 cross on the same sample
      for (int k = 0; k < 5; k++) begin
         send(-4000, 0, 5000);
         if (k == 3) check("tie_nd_4th", nd, 3'b000);
      end
      check("tie_nd",    nd,    3'b101);
      check("tie_state", state, POST);
      check("tie_trig",  trig,  0);
      quiet(255);
      check("tie_post_255", state, POST);
      quiet(1);
      check("tie_frozen", frz, 1);

      // Rearm with coincident sample and a read in flight
      bus.rd_req   = 1'b1;
      bus.rd_idx   = 9'd511;
      rearm        = 1'b1;
      bus.data     = {DW'(0), DW'(0), DW'(1000)};
      bus.data_rdy = 1'b1;
      step();
      rearm        = 1'b0;
      bus.data_rdy = 1'b0;
      bus.rd_req   = 1'b0;
      check("inflight_rd", {bus.rd_valid, bus.rd_data}, {1'b1, DW'(0), DW'(0), DW'(1000)});
      check("rearm2_state",  state, FILL);
      check("rearm2_frozen", frz,   0);
      check("rearm2_trig",   trig,  0);
      step();
      bus.rd_req = 1'b1;
      bus.rd_idx = '0;
      step();
      bus.rd_req = 1'b0;
      check("rd_after_rearm", bus.rd_valid, 0);
      quiet(254);
      check("rearm2_fill_255", state, FILL);
      quiet(1);
      check("rearm2_armed", state, ARMED);

      // Calibration boundary on channel 0 (offset 1000)
      repeat (5) send(1000, 0, 0);
      check("cal_zero_nd", nd, 3'b000);
      repeat (5) send(-3096, 0, 0);
      check("cal_equal_nd",    nd,    3'b000);
      check("cal_equal_state", state, ARMED);
      send(-3097, 0, 0);
      check("cal_over_nd",    nd,    3'b001);
      check("cal_over_state", state, POST);
      check("cal_over_trig",  trig,  0);

      // Asynchronous reset in the middle of POST
      quiet(10);
      check("mid_post_state", state, POST);
      #2 reset_n = 1'b0;
      #1;
      check("areset_state",  state,        FILL);
      check("areset_frozen", frz,          0);
      check("areset_nd",     nd,           0);
      check("areset_trig",   trig,         0);
      check("areset_rdv",    bus.rd_valid, 0);
      #2 reset_n = 1'b1;
      step();
      quiet(255);
      check("reset_fill_255", state, FILL);
      quiet(1);
      check("reset_armed_256", state, ARMED);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multichannel_capture_buffer.md
Name: multichannel_capture_buffer

Overview:
- Per-microphone capture buffer for the TDOA path. Generalises the single-channel noise buffer to CHANNELS microphones, each with its own calibration offset.
- Each channel gets a rectified running-sum energy detector. The block stores raw samples in circular buffers.
- On the first over-threshold channel it captures POST_TRIG further samples, then freezes. The frozen pre- and post-trigger history is read out for cross-correlation, then the block is re-armed.

Parameters:
- CHANNELS, 3: number of microphone channels.
- DATA_W, 18: sample width, signed two's complement.
- DEPTH, 512: samples stored per channel; must be a power of 2.
- WINDOW_SIZE, 5: energy window length in samples; 1 to 64.
- THRESHOLD, 4096: per-sample average rectified level that triggers.
- POST_TRIG, 256: samples captured after trigger; 1 to DEPTH-1.
- CALIB_VALS, all 0: packed CHANNELS x DATA_W signed DC offsets, one per channel.

Ports:
- clock, in, 1: sole clock.
- reset_n, in, 1: asynchronous, active-low reset.
- data, in, CHANNELS x DATA_W: one sample per channel, all simultaneous.
- data_rdy, in, 1: data valid for one cycle; the sample strobe.
- rearm, in, 1: single-cycle pulse; restarts capture.
- rd_req, in, 1: read request; honoured only in FROZEN.
- rd_idx, in, clog2(DEPTH): chronological index; 0 is the oldest sample.
- rd_valid, out, 1: rd_data valid.
- rd_data, out, CHANNELS x DATA_W: raw samples at rd_idx.
- noise_detected, out, CHANNELS: live per-channel detector output.
- frozen, out, 1: capture complete; buffer readable.
- trig_channel, out, clog2(CHANNELS) (min 1): channel that caused the trigger.
- state_o, out, 2: current state, for debug.

Behaviour:
- Reset: asynchronous, active-low. On reset:
  - state goes to FILL;
  - all counters and pointers are 0;
  - energy windows and sums are 0;
  - every output is 0.
  - Sample memory is not cleared and may be RAM.
- Per sample (data_rdy=1), every state except FROZEN:
  - data[c] is written at wr_ptr; wr_ptr increments, wrapping at DEPTH.
- Rectification: r[c] = |data[c] - CALIB_VALS[c]|.
  - Computed with DATA_W+1-bit signed arithmetic.
  - Saturated to the unsigned DATA_W maximum.
- Energy: sum[c] tracks the last WINDOW_SIZE values of r[c].
  - Updated incrementally per data_rdy: add the new value, subtract the oldest.
  - Width is clog2(WINDOW_SIZE)+DATA_W; the sum can never overflow.
  - noise_detected[c] = sum[c] > WINDOW_SIZE*THRESHOLD, registered, valid the cycle after data_rdy.
  - The energy path runs in all states, including FROZEN.
- State machine:
  - FILL: counts samples written since entry. After DEPTH-POST_TRIG samples, go to ARMED. A detection during FILL is ignored, which guarantees full pre-trigger history.
  - ARMED: on the first cycle any noise_detected bit is 1:
    - latch trig_channel as the lowest asserted index (ties go to the lower channel);
    - go to POST with post_cnt=0.
  - POST: each data_rdy writes and increments post_cnt. When the POST_TRIG-th post-trigger sample is written, go to FROZEN on the next edge. Further detections are ignored.
  - FROZEN:
    - frozen=1; writes stop and wr_ptr holds.
    - The physical address is (wr_ptr + rd_idx) mod DEPTH, so rd_idx=DEPTH-POST_TRIG-1 is the last pre-trigger sample.
- Readout:
  - rd_req in FROZEN gives rd_valid=1 and rd_data exactly 1 cycle later. Back-to-back requests are allowed, one per cycle.
  - rd_req outside FROZEN is ignored; rd_valid stays 0.
- rearm in any state:
  - go to FILL with the fill counter cleared and post_cnt cleared;
  - frozen and trig_channel go to 0.
  - If data_rdy coincides with rearm, that sample is written and counts as fill sample 1.
  - A read in flight when rearm arrives still completes.
- Simultaneous detection on the cycle the FILL threshold is reached: stay non-triggered; the detection is evaluated from ARMED onward.

Optional Feature:
- Macro: CAPTURE_TIMESTAMP_EN.
- When defined:
  - a free-running 32-bit sample counter increments on each data_rdy and wraps;
  - output trig_timestamp [31:0] latches the counter value on the ARMED-to-POST transition and holds until rearm or reset, where it returns to 0.
- When undefined: no counter and no port.

Decomposition:
- Shared package (capture_pkg):
  - state enum {FILL, ARMED, POST, FROZEN};
  - rectify function (generalised to DATA_W with a saturation rule);
  - helper computing SUM_W.
- One natural sub-module: channel_energy_detector. One instance per channel, holding the rectifier, window shift register, running sum and comparator.

Test Plan:
- Reset mid-POST: assert reset_n=0 → state=FILL, frozen=0, noise_detected=0 immediately. Then 255 quiet samples → still FILL; sample 256 (DEPTH-POST_TRIG) → ARMED.
- Ramp trigger: data[c] = sample index (sample counter driven onto all channels), CALIB 0. Raise channel 1 to 5000 for 5 samples after arming → trig_channel=1. Exactly 256 more samples → frozen=1. Read idx 0..511 → sequence contiguous; idx 255 is last pre-trigger.
- Tie: channels 0 and 2 exceed threshold on the same sample → trig_channel=0.
- Calibration: CALIB_VALS[0]=1000, constant input 1000 → sum 0, no trigger. Input -3096 for 5 samples → r=4096, sum=20480, not > 20480, so no trigger. Input -3097 → trigger.
- Saturation: data=-131072 with CALIB=131071 → r=262143 saturated, sum without overflow.
- Rearm while FROZEN with coincident data_rdy → FILL, frozen=0. Subsequent rd_req → rd_valid stays 0. 255 more samples → ARMED.
